ccc_lock_reset_sequencer: RTL and testbench
===========================================

Name: ccc_lock_reset_sequencer

Overview:
- Parametrised reset/lock manager that sits beside the fabric CCC and runs on the free-running RCOSC-derived clock.
- Pulses the PLL reset and qualifies the raw CCC LOCK with a synchroniser and stability filter.
- Releases NUM_CH per-domain resets in a staggered order, one for each GL output domain.
- Handles loss of lock, lock timeout with bounded retries, and a software resequence request; earlier CCC wrappers did none of this.

Parameters:
NUM_CH, 4, number of sequenced reset channels (1..8)
PLL_RST_CYCLES, 32, cycles PLL_ARST_N is held low per PLL reset pulse (>=1)
LOCK_FILTER, 16, consecutive synchronised-high LOCK cycles required to accept lock (>=1)
STAGE_GAP, 8, cycles between successive channel releases (>=1)
LOCK_TIMEOUT, 65536, cycles allowed in WAIT_LOCK before a retry (>LOCK_FILTER)
MAX_RETRIES, 3, PLL reset retries before FAIL (>=0)

Ports:
CLK  input  1  free-running sequencer clock
RESET_N  input  1  asynchronous active-low reset
LOCK  input  1  raw CCC lock, asynchronous to CLK
SW_RST_REQ  input  1  synchronous single-cycle request to resequence from PLL reset
PLL_ARST_N  output  1  drives CCC PLL_ARST_N, active low
CH_RESET_N  output  NUM_CH  per-domain resets, active low, registered
ALL_READY  output  1  high only in RUN
LOCK_LOST  output  1  one-cycle pulse on loss of lock during RELEASE/RUN
TIMEOUT_ERR  output  1  sticky, high in FAIL
RETRY_CNT  output  clog2(MAX_RETRIES+1) (min 1)  retries used in current attempt
STATE  output  3  encoded state: 0 PLL_RST, 1 WAIT_LOCK, 2 RELEASE, 3 RUN, 4 FAIL

Behaviour:
- Clock and reset: one clock, CLK; RESET_N is asynchronous, active-low.
- Reset values:
  - STATE=PLL_RST, PLL_ARST_N=0, CH_RESET_N=all 0, ALL_READY=0, LOCK_LOST=0, TIMEOUT_ERR=0, RETRY_CNT=0.
  - All counters are 0.
- LOCK synchroniser:
  - 2-flop synchroniser gives lock_s, 2 cycles of latency.
  - Synchroniser flops reset to 0.
- PLL_RST:
  - PLL_ARST_N=0 for exactly PLL_RST_CYCLES cycles, then WAIT_LOCK with PLL_ARST_N=1.
  - Timeout and filter counters are cleared on exit.
- WAIT_LOCK:
  - Filter counter increments while lock_s=1 and clears to 0 when lock_s=0.
  - Reaching LOCK_FILTER -> RELEASE.
  - Timeout counter increments every cycle. Reaching LOCK_TIMEOUT with no lock:
    - if RETRY_CNT<MAX_RETRIES: RETRY_CNT+1 and -> PLL_RST;
    - else -> FAIL with TIMEOUT_ERR=1.
  - If lock acceptance and timeout occur in the same cycle, lock acceptance wins.
- RELEASE:
  - Channel k (k=0..NUM_CH-1) deasserts CH_RESET_N[k] exactly (k+1)*STAGE_GAP cycles after the RELEASE-entry edge.
  - Release order is ascending; a released channel stays high.
  - On the edge that releases channel NUM_CH-1: ALL_READY=1, RETRY_CNT=0, -> RUN.
- RUN: hold all outputs; ALL_READY=1.
- Loss of lock (lock_s=0 in RELEASE or RUN):
  - On the next edge: CH_RESET_N=all 0, ALL_READY=0, LOCK_LOST=1 for one cycle, -> WAIT_LOCK.
  - Timeout and filter counters restart at 0; RETRY_CNT is unchanged; no PLL reset is issued.
- FAIL:
  - PLL_ARST_N=1, CH_RESET_N=all 0, TIMEOUT_ERR=1.
  - Exit only via SW_RST_REQ.
- SW_RST_REQ:
  - Accepted in any state.
  - Next edge: CH_RESET_N=all 0, ALL_READY=0, TIMEOUT_ERR=0, RETRY_CNT=0, -> PLL_RST with a fresh PLL_RST_CYCLES count.
  - Priority: SW_RST_REQ > loss of lock > timeout > normal progression.
  - SW_RST_REQ asserted for multiple cycles restarts PLL_RST each cycle.
- RESET_N asserted mid-sequence: all outputs return to their reset values immediately (asynchronously).
- No combinational path from any input to any output.

Test Plan:
Each scenario uses NUM_CH=3, PLL_RST_CYCLES=4, LOCK_FILTER=4, STAGE_GAP=3, LOCK_TIMEOUT=50, MAX_RETRIES=2.
1. Nominal bring-up:
   - Stimulus: release RESET_N; LOCK goes high 10 cycles later.
   - Required: PLL_ARST_N low for 4 cycles; STATE=RELEASE 6 cycles after LOCK rises (2 sync + 4 filter).
   - Required: CH_RESET_N goes 001, 011, 111 at +3/+6/+9 cycles; ALL_READY=1 with 111; RETRY_CNT=0.
2. Glitchy lock: LOCK high 3 cycles, low 1, then high steady -> filter restarts; RELEASE entered only after 4 consecutive lock_s highs.
3. Timeout/retry/fail: LOCK held 0 -> three WAIT_LOCK timeouts of 50 cycles; PLL_ARST_N pulsed after the first two; RETRY_CNT 1 then 2; then STATE=FAIL, TIMEOUT_ERR=1, CH_RESET_N=000.
4. Loss of lock:
   - Stimulus: in RUN, drop LOCK for 1 cycle.
   - Required: 3 cycles later (2 sync + 1 edge) CH_RESET_N=000, one-cycle LOCK_LOST, STATE=WAIT_LOCK, PLL_ARST_N stays 1; resequence completes once LOCK returns.
5. Priority: SW_RST_REQ on the same cycle lock_s falls in RUN -> STATE=PLL_RST (not WAIT_LOCK), LOCK_LOST stays 0. SW_RST_REQ in FAIL -> TIMEOUT_ERR clears and PLL_RST restarts.
6. Async reset mid-RELEASE with CH_RESET_N=011: assert RESET_N -> outputs go to 000/PLL_ARST_N=0 without a clock edge; normal sequence restarts after release.

Source files
------------

// File: rtl/ccc_lock_reset_sequencer.sv
// ccc_lock_reset_sequencer: PLL reset pulse, LOCK qualification and
// staggered per-domain reset release beside the fabric CCC.
//
// Ports:
//   CLK          free-running sequencer clock (RCOSC derived)
//   RESET_N      asynchronous active-low reset
//   LOCK         raw CCC lock, asynchronous to CLK
//   SW_RST_REQ   single-cycle request to resequence from PLL reset
//   PLL_ARST_N   CCC PLL reset, active low
//   CH_RESET_N   per-domain resets, active low, released in ascending order
//   ALL_READY    high only in RUN
//   LOCK_LOST    one-cycle pulse when lock drops in RELEASE/RUN
//   TIMEOUT_ERR  sticky failure flag, high in FAIL
//   RETRY_CNT    PLL reset retries used in the current attempt
//   STATE        0 PLL_RST, 1 WAIT_LOCK, 2 RELEASE, 3 RUN, 4 FAIL

module ccc_lock_reset_sequencer #(
   parameter int NUM_CH         = 4,
   parameter int PLL_RST_CYCLES = 32,
   parameter int LOCK_FILTER    = 16,
   parameter int STAGE_GAP      = 8,
   parameter int LOCK_TIMEOUT   = 65536,
   parameter int MAX_RETRIES    = 3,
   localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              LOCK,
   input  logic              SW_RST_REQ,
   output logic              PLL_ARST_N,
   output logic [NUM_CH-1:0] CH_RESET_N,
   output logic              ALL_READY,
   output logic              LOCK_LOST,
   output logic              TIMEOUT_ERR,
   output logic [RW-1:0]     RETRY_CNT,
   output logic [2:0]        STATE
);

   localparam int PW = $clog2(PLL_RST_CYCLES + 1);
   localparam int FW = $clog2(LOCK_FILTER + 1);
   localparam int TW = $clog2(LOCK_TIMEOUT + 1);
   localparam int GW = $clog2(STAGE_GAP + 1);
   localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam logic [PW-1:0] P_LAST = PW'(PLL_RST_CYCLES - 1);
   localparam logic [FW-1:0] F_LAST = FW'(LOCK_FILTER - 1);
   localparam logic [TW-1:0] T_LAST = TW'(LOCK_TIMEOUT - 1);
   localparam logic [GW-1:0] G_LAST = GW'(STAGE_GAP - 1);
   localparam logic [CW-1:0] C_LAST = CW'(NUM_CH - 1);
   localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_PLL_RST = 3'd0,
      S_WAIT    = 3'd1,
      S_RELEASE = 3'd2,
      S_RUN     = 3'd3,
      S_FAIL    = 3'd4
   } state_t;

   state_t            r_state, w_state_n;
   logic [1:0]        r_sync;
   logic [PW-1:0]     r_pcnt, w_pcnt_n;
   logic [FW-1:0]     r_filt, w_filt_n;
   logic [TW-1:0]     r_tmo, w_tmo_n;
   logic [GW-1:0]     r_gap, w_gap_n;
   logic [CW-1:0]     r_idx, w_idx_n;
   logic [RW-1:0]     r_retry, w_retry_n;
   logic              r_pll, w_pll_n;
   logic [NUM_CH-1:0] r_ch, w_ch_n;
   logic              r_ready, w_ready_n;
   logic              r_lost, w_lost_n;
   logic              r_terr, w_terr_n;

   logic              w_lock_s;
   logic              w_live;
   logic [NUM_CH-1:0] w_ch_set;

   assign w_lock_s = r_sync[1];
   assign w_live   = (r_state == S_RELEASE) || (r_state == S_RUN);
   // Released channels accumulate: OR in the next one, never clear here.
   assign w_ch_set = r_ch | (NUM_CH'(1) << r_idx);

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_sync <= 2'b00;
      end else begin
         r_sync <= {r_sync[0], LOCK};
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state <= S_PLL_RST;
         r_pcnt  <= '0;
         r_filt  <= '0;
         r_tmo   <= '0;
         r_gap   <= '0;
         r_idx   <= '0;
         r_retry <= '0;
         r_pll   <= 1'b0;
         r_ch    <= '0;
         r_ready <= 1'b0;
         r_lost  <= 1'b0;
         r_terr  <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_pcnt  <= w_pcnt_n;
         r_filt  <= w_filt_n;
         r_tmo   <= w_tmo_n;
         r_gap   <= w_gap_n;
         r_idx   <= w_idx_n;
         r_retry <= w_retry_n;
         r_pll   <= w_pll_n;
         r_ch    <= w_ch_n;
         r_ready <= w_ready_n;
         r_lost  <= w_lost_n;
         r_terr  <= w_terr_n;
      end
   end

   always_comb begin
      w_state_n = r_state;
      w_pcnt_n  = r_pcnt;
      w_filt_n  = r_filt;
      w_tmo_n   = r_tmo;
      w_gap_n   = r_gap;
      w_idx_n   = r_idx;
      w_retry_n = r_retry;
      w_pll_n   = r_pll;
      w_ch_n    = r_ch;
      w_ready_n = r_ready;
      w_lost_n  = 1'b0;
      w_terr_n  = r_terr;

      if (SW_RST_REQ) begin
         // Full restart; repeated requests keep reloading the pulse.
         w_state_n = S_PLL_RST;
         w_pcnt_n  = '0;
         w_filt_n  = '0;
         w_tmo_n   = '0;
         w_gap_n   = '0;
         w_idx_n   = '0;
         w_retry_n = '0;
         w_pll_n   = 1'b0;
         w_ch_n    = '0;
         w_ready_n = 1'b0;
         w_terr_n  = 1'b0;
      end else if (w_live && !w_lock_s) begin
         // Lock dropped: re-qualify without another PLL reset.
         w_state_n = S_WAIT;
         w_filt_n  = '0;
         w_tmo_n   = '0;
         w_gap_n   = '0;
         w_idx_n   = '0;
         w_ch_n    = '0;
         w_ready_n = 1'b0;
         w_lost_n  = 1'b1;
      end else begin
         unique case (r_state)
            S_PLL_RST: begin
               if (r_pcnt == P_LAST) begin
                  w_state_n = S_WAIT;
                  w_pcnt_n  = '0;
                  w_pll_n   = 1'b1;
                  w_filt_n  = '0;
                  w_tmo_n   = '0;
               end else begin
                  w_pcnt_n = r_pcnt + 1'b1;
               end
            end
            S_WAIT: begin
               w_tmo_n  = r_tmo + 1'b1;
               w_filt_n = w_lock_s ? r_filt + 1'b1 : '0;
               // Acceptance is checked first so it wins a tie with timeout.
               if (w_lock_s && (r_filt == F_LAST)) begin
                  w_state_n = S_RELEASE;
                  w_filt_n  = '0;
                  w_tmo_n   = '0;
                  w_gap_n   = '0;
                  w_idx_n   = '0;
               end else if (r_tmo == T_LAST) begin
                  w_filt_n = '0;
                  w_tmo_n  = '0;
                  if (r_retry < R_MAX) begin
                     w_retry_n = r_retry + 1'b1;
                     w_state_n = S_PLL_RST;
                     w_pcnt_n  = '0;
                     w_pll_n   = 1'b0;
                  end else begin
                     w_state_n = S_FAIL;
                     w_terr_n  = 1'b1;
                  end
               end
            end
            S_RELEASE: begin
               if (r_gap == G_LAST) begin
                  w_gap_n = '0;
                  w_ch_n  = w_ch_set;
                  if (r_idx == C_LAST) begin
                     w_state_n = S_RUN;
                     w_ready_n = 1'b1;
                     w_retry_n = '0;
                     w_idx_n   = '0;
                  end else begin
                     w_idx_n = r_idx + 1'b1;
                  end
               end else begin
                  w_gap_n = r_gap + 1'b1;
               end
            end
            S_RUN: begin
               w_ready_n = 1'b1;
            end
            S_FAIL: begin
               w_pll_n  = 1'b1;
               w_ch_n   = '0;
               w_terr_n = 1'b1;
            end
            default: begin
               w_state_n = S_PLL_RST;
               w_pcnt_n  = '0;
               w_pll_n   = 1'b0;
               w_ch_n    = '0;
               w_ready_n = 1'b0;
            end
         endcase
      end
   end

   assign PLL_ARST_N  = r_pll;
   assign CH_RESET_N  = r_ch;
   assign ALL_READY   = r_ready;
   assign LOCK_LOST   = r_lost;
   assign TIMEOUT_ERR = r_terr;
   assign RETRY_CNT   = r_retry;
   assign STATE       = r_state;

endmodule

// File: tb/tb_ccc_lock_reset_sequencer.sv
// tb_ccc_lock_reset_sequencer: directed bench for the CCC lock/reset
// sequencer with NUM_CH=3, PLL_RST_CYCLES=4, LOCK_FILTER=4, STAGE_GAP=3.

module tb_ccc_lock_reset_sequencer;

   logic       CLK = 1'b0;
   logic       RESET_N = 1'b1;
   logic       LOCK = 1'b0;
   logic       SW_RST_REQ = 1'b0;
   logic       PLL_ARST_N;
   logic [2:0] CH_RESET_N;
   logic       ALL_READY;
   logic       LOCK_LOST;
   logic       TIMEOUT_ERR;
   logic [1:0] RETRY_CNT;
   logic [2:0] STATE;

   int n_vec = 0;
   int n_err = 0;

   localparam int ST_PLL = 0;
   localparam int ST_WAIT = 1;
   localparam int ST_REL = 2;
   localparam int ST_RUN = 3;
   localparam int ST_FAIL = 4;

   ccc_lock_reset_sequencer #(
      .NUM_CH(3),
      .PLL_RST_CYCLES(4),
      .LOCK_FILTER(4),
      .STAGE_GAP(3),
      .LOCK_TIMEOUT(50),
      .MAX_RETRIES(2)
   ) dut (
      .CLK(CLK),
      .RESET_N(RESET_N),
      .LOCK(LOCK),
      .SW_RST_REQ(SW_RST_REQ),
      .PLL_ARST_N(PLL_ARST_N),
      .CH_RESET_N(CH_RESET_N),
      .ALL_READY(ALL_READY),
      .LOCK_LOST(LOCK_LOST),
      .TIMEOUT_ERR(TIMEOUT_ERR),
      .RETRY_CNT(RETRY_CNT),
      .STATE(STATE)
   );

   always #5 CLK = ~CLK;

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset values, no clock edge needed
      #1 RESET_N = 1'b0;
      #2;
      chk("rst_state", STATE, ST_PLL);
      chk("rst_pll", PLL_ARST_N, 0);
      chk("rst_ch", CH_RESET_N, 3'b000);
      chk("rst_ready", ALL_READY, 0);
      chk("rst_lost", LOCK_LOST, 0);
      chk("rst_terr", TIMEOUT_ERR, 0);
      chk("rst_retry", RETRY_CNT, 0);
      tick(2);
      RESET_N = 1'b1;

      // 1. nominal bring-up
      tick(3);
      chk("s1_pll_low3", PLL_ARST_N, 0);
      chk("s1_state_pll", STATE, ST_PLL);
      tick(1);
      chk("s1_pll_high4", PLL_ARST_N, 1);
      chk("s1_state_wait", STATE, ST_WAIT);
      tick(6);
      LOCK = 1'b1;
      tick(5);
      chk("s1_wait_lock5", STATE, ST_WAIT);
      tick(1);
      chk("s1_release6", STATE, ST_REL);
      tick(2);
      chk("s1_ch_p2", CH_RESET_N, 3'b000);
      tick(1);
      chk("s1_ch_p3", CH_RESET_N, 3'b001);
      tick(3);
      chk("s1_ch_p6", CH_RESET_N, 3'b011);
      tick(2);
      chk("s1_ready_p8", ALL_READY, 0);
      tick(1);
      chk("s1_ch_p9", CH_RESET_N, 3'b111);
      chk("s1_ready_p9", ALL_READY, 1);
      chk("s1_run", STATE, ST_RUN);
      chk("s1_retry", RETRY_CNT, 0);

      // 4. loss of lock for one cycle in RUN
      LOCK = 1'b0;
      tick(1);
      LOCK = 1'b1;
      tick(1);
      chk("s4_hold_ch", CH_RESET_N, 3'b111);
      tick(1);
      chk("s4_ch_clr", CH_RESET_N, 3'b000);
      chk("s4_lost", LOCK_LOST, 1);
      chk("s4_state", STATE, ST_WAIT);
      chk("s4_pll", PLL_ARST_N, 1);
      chk("s4_ready", ALL_READY, 0);
      tick(1);
      chk("s4_lost_pulse", LOCK_LOST, 0);
      tick(2);
      chk("s4_wait", STATE, ST_WAIT);
      tick(1);
      chk("s4_rel", STATE, ST_REL);
      tick(9);
      chk("s4_run_ch", CH_RESET_N, 3'b111);
      chk("s4_run", STATE, ST_RUN);

      // 5a. SW request on the cycle lock_s falls
      LOCK = 1'b0;
      tick(2);
      SW_RST_REQ = 1'b1;
      tick(1);
      SW_RST_REQ = 1'b0;
      chk("s5_state", STATE, ST_PLL);
      chk("s5_lost", LOCK_LOST, 0);
      chk("s5_pll", PLL_ARST_N, 0);
      chk("s5_ch", CH_RESET_N, 3'b000);

      // 3. timeouts, retries, FAIL (LOCK held low)
      tick(4);
      chk("s3_wait0", STATE, ST_WAIT);
      tick(49);
      chk("s3_wait49", STATE, ST_WAIT);
      chk("s3_retry0", RETRY_CNT, 0);
      tick(1);
      chk("s3_to1_state", STATE, ST_PLL);
      chk("s3_to1_retry", RETRY_CNT, 1);
      chk("s3_to1_pll", PLL_ARST_N, 0);
      tick(3);
      chk("s3_pulse2_low", PLL_ARST_N, 0);
      tick(1);
      chk("s3_wait1", STATE, ST_WAIT);
      tick(50);
      chk("s3_to2_state", STATE, ST_PLL);
      chk("s3_to2_retry", RETRY_CNT, 2);
      tick(4);
      chk("s3_wait2", STATE, ST_WAIT);
      tick(49);
      chk("s3_wait2_49", STATE, ST_WAIT);
      tick(1);
      chk("s3_fail", STATE, ST_FAIL);
      chk("s3_terr", TIMEOUT_ERR, 1);
      chk("s3_ch", CH_RESET_N, 3'b000);
      chk("s3_pll", PLL_ARST_N, 1);
      tick(5);
      chk("s3_fail_hold", STATE, ST_FAIL);

      // 5b. SW request in FAIL, held three cycles
      SW_RST_REQ = 1'b1;
      tick(1);
      chk("s5b_state", STATE, ST_PLL);
      chk("s5b_terr", TIMEOUT_ERR, 0);
      chk("s5b_retry", RETRY_CNT, 0);
      chk("s5b_pll", PLL_ARST_N, 0);
      tick(2);
      SW_RST_REQ = 1'b0;
      tick(3);
      chk("s5b_restart", STATE, ST_PLL);
      tick(1);
      chk("s5b_wait", STATE, ST_WAIT);

      // 2. glitchy lock restarts the filter
      LOCK = 1'b1;
      tick(3);
      LOCK = 1'b0;
      tick(1);
      LOCK = 1'b1;
      tick(5);
      chk("s2_wait", STATE, ST_WAIT);
      tick(1);
      chk("s2_rel", STATE, ST_REL);

      // 6. async reset mid-RELEASE
      tick(6);
      chk("s6_ch011", CH_RESET_N, 3'b011);
      #2 RESET_N = 1'b0;
      #1;
      chk("s6_ch", CH_RESET_N, 3'b000);
      chk("s6_pll", PLL_ARST_N, 0);
      chk("s6_state", STATE, ST_PLL);
      tick(1);
      RESET_N = 1'b1;
      tick(3);
      chk("s6_pll_low", PLL_ARST_N, 0);
      tick(1);
      chk("s6_wait", STATE, ST_WAIT);
      tick(4);
      chk("s6_rel", STATE, ST_REL);
      tick(9);
      chk("s6_run", STATE, ST_RUN);
      chk("s6_ch111", CH_RESET_N, 3'b111);
      chk("s6_ready", ALL_READY, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
